wb_port_decoder: RTL and testbench
==================================

Name: wb_port_decoder

Overview:
- Parametrised successor to the fixed 16-port address-decoding MMU.
- Routes one pipelined Wishbone master to NPORTS slave ports, selected by a configurable address field.
- Adds an outstanding-transaction limit, a port-mask for unmapped regions with an internal error terminator, and a response-timeout watchdog.
- Sits between each CPU bus (instruction or data) and its RAM/peripheral slaves; replaces per-port bus terminators.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- SELBITS, 4, width of the port-select address field.
- SELLSB, 28, LSB position of the port-select field within adr.
- NPORTS, 16, number of slave ports; must be ≤ 2**SELBITS.
- PORTMASK, all ones (NPORTS bits), bit i = 1 means port i is mapped.
- MAXOUT, 4, maximum accepted-but-unanswered requests; ≥ 1.
- TIMEOUT, 255, cycles without a response before abort; ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_cyc  in  1  master cycle.
- m_stb  in  1  master strobe.
- m_we  in  1  master write enable.
- m_adr  in  AW  master address.
- m_sel  in  DW/8  master byte selects.
- m_dat_m  in  DW  master write data.
- m_dat_s  out  DW  read data returned to master.
- m_ack  out  1  response acknowledge to master.
- m_err  out  1  error response (unmapped port or timeout).
- m_stall  out  1  stall to master.
- s_cyc  out  NPORTS  per-port cycle.
- s_stb  out  NPORTS  per-port strobe.
- s_we  out  1  broadcast write enable.
- s_adr  out  AW  broadcast address.
- s_sel  out  DW/8  broadcast byte selects.
- s_dat_m  out  DW  broadcast write data.
- s_dat_s  in  NPORTS*DW  per-port read data; port i occupies [i*DW +: DW].
- s_ack  in  NPORTS  per-port acknowledge.
- s_stall  in  NPORTS  per-port stall.

Behaviour:
- Decode: dport = m_adr[SELLSB +: SELBITS]. A request is mapped iff dport < NPORTS and PORTMASK[dport] = 1.
- Registers:
  - state: IDLE, ACTIVE, ABORT.
  - cur_port: $clog2(NPORTS) bits.
  - outcnt: $clog2(MAXOUT+1) bits.
  - timer: $clog2(TIMEOUT+1) bits.
  - unmapped-pending flag: uerr_q.
- Reset (rst_i = 1 at a clock edge): state = IDLE; cur_port, outcnt, timer, uerr_q = 0. Outputs: m_ack = 0, m_err = 0, s_cyc = 0, s_stb = 0, m_stall = 0.
- block = (outcnt != 0 && dport != cur_port) || outcnt == MAXOUT || state == ABORT.
  - Port switches therefore wait until every response from the previous port has drained.
- m_stall (combinational) = block | (mapped & s_stall[dport]). An unmapped target never stalls on its own account.
- accept = m_cyc & m_stb & ~m_stall.
- s_stb[i] = m_cyc & m_stb & mapped & dport == i & ~block.
- s_cyc[i] = m_cyc & state != ABORT & ((outcnt != 0 & cur_port == i) | (mapped & dport == i)).
- Broadcast outputs (s_we, s_adr, s_sel, s_dat_m) are wired straight through from the master.
- On accept: cur_port <= dport; state <= ACTIVE.
  - If the request is unmapped, set uerr_q; the next cycle gives m_err = 1 with m_dat_s = 0. Latency is exactly 1.
- Responses:
  - resp = (s_ack[cur_port] & outcnt != 0 & state == ACTIVE) | uerr_q.
  - m_ack = s_ack[cur_port] gated identically to resp (combinational, zero added latency).
  - m_dat_s = s_dat_s[cur_port].
  - Acks arriving while outcnt == 0 or in ABORT are dropped.
- Counter: outcnt <= outcnt + accept − resp. Simultaneous accept and resp leaves it unchanged. It never exceeds MAXOUT and never underflows.
- Watchdog:
  - timer clears on resp, or whenever outcnt == 0.
  - Otherwise it increments each cycle while state == ACTIVE.
  - When timer == TIMEOUT−1 with no resp that cycle: m_err pulses for 1 cycle, outcnt <= 0, state <= ABORT.
- ABORT: all s_cyc/s_stb = 0 and m_stall = 1. Leave to IDLE on the first cycle m_cyc = 0.
- m_cyc = 0 in any state: outcnt, timer, uerr_q <= 0 and state <= IDLE (master-side abort). m_ack/m_err are suppressed that cycle.
- ACTIVE returns to IDLE when outcnt reaches 0 with no accept that cycle.
- m_ack and m_err are never asserted in the same cycle. A timeout error takes priority; a coincident uerr_q is not possible because an unmapped target is always answered before the timer can expire.

Test Plan:
1. Reset, then 4 back-to-back reads to 0x0000_0010..1C (port 0 acking 1 cycle after stb) → no stall; 4 m_ack pulses carrying port-0 data; outcnt returns to 0.
2. MAXOUT = 4, slave withholds ack, 6 stb to port 7 → m_stall rises after the 4th accept. Release acks → remaining 2 accepted; exactly 6 m_ack.
3. Read port 0 (ack delayed 3 cycles), then immediate read port 7 → port-7 stb held off (m_stall = 1) until the port-0 ack; then s_stb[7] = 1 and s_cyc[0] drops.
4. PORTMASK bit 3 = 0, read 0x3000_0000 → no s_stb; m_err = 1 exactly one cycle later; m_dat_s = 0.
5. TIMEOUT = 8, write to port 2 which never acks → m_err pulses 8 cycles after accept; s_cyc = 0 and m_stall = 1 until m_cyc falls. A late port-2 ack produces no m_ack.
6. Assert rst_i mid-burst with outcnt = 3 → next cycle all s_cyc = 0, outcnt = 0, no m_ack/m_err. A new request after reset completes normally.

Source files
------------

// File: rtl/wb_port_decoder.sv
// Routes one pipelined Wishbone master to NPORTS slaves selected by an address field,
// with an outstanding-request limit, an unmapped-port error terminator and a response watchdog.
module wb_port_decoder #(
  parameter int                AW       = 32,
  parameter int                DW       = 32,
  parameter int                SELBITS  = 4,
  parameter int                SELLSB   = 28,
  parameter int                NPORTS   = 16,
  parameter logic [NPORTS-1:0] PORTMASK = '1,
  parameter int                MAXOUT   = 4,
  parameter int                TIMEOUT  = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m_cyc,
  input  logic                 m_stb,
  input  logic                 m_we,
  input  logic [AW-1:0]        m_adr,
  input  logic [DW/8-1:0]      m_sel,
  input  logic [DW-1:0]        m_dat_m,
  output logic [DW-1:0]        m_dat_s,
  output logic                 m_ack,
  output logic                 m_err,
  output logic                 m_stall,
  output logic [NPORTS-1:0]    s_cyc,
  output logic [NPORTS-1:0]    s_stb,
  output logic                 s_we,
  output logic [AW-1:0]        s_adr,
  output logic [DW/8-1:0]      s_sel,
  output logic [DW-1:0]        s_dat_m,
  input  logic [NPORTS*DW-1:0] s_dat_s,
  input  logic [NPORTS-1:0]    s_ack,
  input  logic [NPORTS-1:0]    s_stall
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(MAXOUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cur_port_q, cur_port_d;
  logic [CW-1:0] outcnt_q, outcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          uerr_q, uerr_d;

  logic [SELBITS-1:0] dport, cur_ext;
  logic               mapped, tgt_stall, cur_ack;
  logic [DW-1:0]      cur_dat;
  logic               nonzero, full, active, abort;
  logic               block, accept, ack_ok, tmo, resp;

  assign s_we    = m_we;
  assign s_adr   = m_adr;
  assign s_sel   = m_sel;
  assign s_dat_m = m_dat_m;

  // Loops instead of direct indexing keep out-of-range selects from producing X.
  always_comb begin
    dport     = m_adr[SELLSB +: SELBITS];
    cur_ext   = SELBITS'(cur_port_q);
    mapped    = 1'b0;
    tgt_stall = 1'b0;
    cur_ack   = 1'b0;
    cur_dat   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (dport == SELBITS'(i)) begin
        mapped    = PORTMASK[i];
        tgt_stall = s_stall[i];
      end
      if (cur_port_q == PW'(i)) begin
        cur_ack = s_ack[i];
        cur_dat = s_dat_s[i*DW +: DW];
      end
    end
  end

  always_comb begin
    nonzero = (outcnt_q != '0);
    full    = (outcnt_q == CW'(MAXOUT));
    active  = (state_q == ACTIVE);
    abort   = (state_q == ABORT);
    block   = (nonzero && (dport != cur_ext)) || full || abort;
    m_stall = block | (mapped & tgt_stall);
    accept  = m_cyc & m_stb & ~m_stall;
    ack_ok  = cur_ack & nonzero & active & ~uerr_q;
    tmo     = active & nonzero & (timer_q == TW'(TIMEOUT - 1)) & ~ack_ok & ~uerr_q;
    resp    = ack_ok | uerr_q;
    m_ack   = m_cyc & ack_ok;
    m_err   = m_cyc & (uerr_q | tmo);
    m_dat_s = uerr_q ? '0 : cur_dat;
    s_stb   = '0;
    s_cyc   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      s_stb[i] = m_cyc & m_stb & mapped & (dport == SELBITS'(i)) & ~block;
      s_cyc[i] = m_cyc & ~abort & ((nonzero & (cur_port_q == PW'(i))) |
                                   (mapped & (dport == SELBITS'(i))));
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_port_d = cur_port_q;
    outcnt_d   = outcnt_q;
    timer_d    = timer_q;
    uerr_d     = 1'b0;
    if (!m_cyc) begin
      state_d  = IDLE;
      outcnt_d = '0;
      timer_d  = '0;
    end else if (abort) begin
      outcnt_d = '0;
      timer_d  = '0;
    end else if (tmo) begin
      state_d  = ABORT;
      outcnt_d = '0;
      timer_d  = '0;
    end else begin
      outcnt_d = outcnt_q + CW'(accept) - CW'(resp);
      uerr_d   = accept & ~mapped;
      if (accept) begin
        cur_port_d = PW'(dport);
        state_d    = ACTIVE;
      end else if (active && (outcnt_d == '0)) begin
        state_d = IDLE;
      end
      if (resp || !nonzero) timer_d = '0;
      else if (active)      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_port_q <= '0;
      outcnt_q   <= '0;
      timer_q    <= '0;
      uerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_port_q <= cur_port_d;
      outcnt_q   <= outcnt_d;
      timer_q    <= timer_d;
      uerr_q     <= uerr_d;
    end
  end

endmodule

// File: tb/tb_wb_port_decoder.sv
// Directed bench for wb_port_decoder: port 3 unmapped, TIMEOUT 8, MAXOUT 4.
module tb_wb_port_decoder;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m_cyc, m_stb, m_we;
  logic [31:0]   m_adr;
  logic [3:0]    m_sel;
  logic [31:0]   m_dat_m;
  logic [31:0]   m_dat_s;
  logic          m_ack, m_err, m_stall;
  logic [15:0]   s_cyc, s_stb;
  logic          s_we;
  logic [31:0]   s_adr;
  logic [3:0]    s_sel;
  logic [31:0]   s_dat_m;
  logic [511:0]  s_dat_s;
  logic [15:0]   s_ack, s_stall;

  int n_cmp = 0;
  int n_err = 0;
  int acks;

  wb_port_decoder #(.PORTMASK(16'hFFF7), .MAXOUT(4), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_m(m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack), .m_err(m_err),
    .m_stall(m_stall), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack),
    .s_stall(s_stall)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic cyc, input logic stb, input logic we, input logic [31:0] adr);
    @(negedge clk_i);
    m_cyc = cyc;
    m_stb = stb;
    m_we  = we;
    m_adr = adr;
  endtask

  logic [11:0] t2_stb   = 12'b0000_1111_1111;
  logic [11:0] t2_ack   = 12'b1111_1110_0000;
  logic [11:0] t2_stall = 12'b0000_0011_0000;
  logic [11:0] t2_mack  = 12'b0111_1110_0000;

  initial begin
    rst_i = 1'b1; m_cyc = 0; m_stb = 0; m_we = 0; m_adr = '0;
    m_sel = 4'hF; m_dat_m = 32'h1234_5678; s_ack = '0; s_stall = '0;
    for (int i = 0; i < 16; i++) s_dat_s[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_stall", m_stall, 0);
    chk("rst_outcnt", dut.outcnt_q, 0);

    // 1: back-to-back reads on port 0, ack one cycle after each strobe
    for (int k = 0; k < 5; k++) begin
      bus(1, k < 4, 0, 32'h10 + 32'(4 * k));
      s_ack[0] = (k >= 1);
      s_dat_s[31:0] = 32'hBEEF_0000 + 32'(k);
      #1;
      if (k < 4) begin
        chk($sformatf("t1_stall_%0d", k), m_stall, 0);
        chk($sformatf("t1_sstb_%0d", k), s_stb, 16'h0001);
      end
      chk($sformatf("t1_ack_%0d", k), m_ack, k >= 1);
      if (k >= 1) chk($sformatf("t1_dat_%0d", k), m_dat_s, 32'hBEEF_0000 + 32'(k));
    end
    bus(1, 0, 0, 32'h0);
    s_ack = '0;
    #1;
    chk("t1_ack_end", m_ack, 0);
    chk("t1_outcnt", dut.outcnt_q, 0);

    // 2: outstanding limit on port 7
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      bus(1, t2_stb[k], 0, 32'h7000_0000);
      s_ack = '0;
      s_ack[7] = t2_ack[k];
      #1;
      chk($sformatf("t2_stall_%0d", k), m_stall, t2_stall[k]);
      chk($sformatf("t2_ack_%0d", k), m_ack, t2_mack[k]);
      if (m_ack) acks++;
    end
    chk("t2_ackcount", acks, 6);
    chk("t2_outcnt", dut.outcnt_q, 0);

    // 3: port switch waits for port-0 drain
    bus(1, 1, 0, 32'h0000_0000);
    s_ack = '0;
    #1;
    chk("t3_acc0", m_stall, 0);
    for (int k = 1; k < 3; k++) begin
      bus(1, 1, 0, 32'h7000_0000);
      #1;
      chk($sformatf("t3_stall_%0d", k), m_stall, 1);
      chk($sformatf("t3_sstb_%0d", k), s_stb, 0);
      chk($sformatf("t3_scyc_%0d", k), s_cyc, 16'h0081);
    end
    bus(1, 1, 0, 32'h7000_0000);
    s_ack[0] = 1'b1;
    #1;
    chk("t3_ack0", m_ack, 1);
    chk("t3_stall_ack", m_stall, 1);
    bus(1, 1, 0, 32'h7000_0000);
    s_ack = '0;
    #1;
    chk("t3_stall_free", m_stall, 0);
    chk("t3_sstb7", s_stb, 16'h0080);
    chk("t3_scyc7", s_cyc, 16'h0080);
    bus(1, 0, 0, 32'h7000_0000);
    s_ack[7] = 1'b1;
    #1;
    chk("t3_ack7", m_ack, 1);
    chk("t3_dat7", m_dat_s, 32'hC0DE_0007);
    bus(1, 0, 0, 32'h7000_0000);
    s_ack = '0;
    #1;
    chk("t3_ack_end", m_ack, 0);

    // 4: unmapped port 3
    bus(1, 1, 0, 32'h3000_0000);
    #1;
    chk("t4_sstb", s_stb, 0);
    chk("t4_stall", m_stall, 0);
    chk("t4_err_early", m_err, 0);
    bus(1, 0, 0, 32'h3000_0000);
    #1;
    chk("t4_err", m_err, 1);
    chk("t4_ack", m_ack, 0);
    chk("t4_dat", m_dat_s, 0);
    bus(1, 0, 0, 32'h3000_0000);
    #1;
    chk("t4_err_end", m_err, 0);

    // 5: watchdog on a write to port 2 that never acks
    bus(1, 1, 1, 32'h2000_0000);
    #1;
    chk("t5_acc", m_stall, 0);
    for (int k = 1; k < 8; k++) begin
      bus(1, 0, 1, 32'h2000_0000);
      #1;
      chk($sformatf("t5_noerr_%0d", k), m_err, 0);
    end
    bus(1, 0, 1, 32'h2000_0000);
    #1;
    chk("t5_err", m_err, 1);
    chk("t5_err_ack", m_ack, 0);
    bus(1, 1, 1, 32'h2000_0000);
    #1;
    chk("t5_err_pulse", m_err, 0);
    chk("t5_scyc", s_cyc, 0);
    chk("t5_sstb", s_stb, 0);
    chk("t5_stall", m_stall, 1);
    bus(1, 0, 1, 32'h2000_0000);
    s_ack[2] = 1'b1;
    #1;
    chk("t5_late_ack", m_ack, 0);
    chk("t5_stall2", m_stall, 1);
    bus(0, 0, 0, 32'h2000_0000);
    #1;
    chk("t5_cyc0_ack", m_ack, 0);
    bus(1, 0, 0, 32'h2000_0000);
    s_ack = '0;
    #1;
    chk("t5_idle_stall", m_stall, 0);

    // 6: synchronous reset mid-burst
    for (int k = 0; k < 3; k++) begin
      bus(1, 1, 0, 32'h5000_0000);
      #1;
      chk($sformatf("t6_acc_%0d", k), m_stall, 0);
    end
    bus(1, 0, 0, 32'h5000_0000);
    #1;
    chk("t6_outcnt3", dut.outcnt_q, 3);
    rst_i = 1'b1;
    bus(1, 0, 0, 32'h3000_0000);
    rst_i = 1'b0;
    s_ack[5] = 1'b1;
    #1;
    chk("t6_scyc", s_cyc, 0);
    chk("t6_outcnt0", dut.outcnt_q, 0);
    chk("t6_ack", m_ack, 0);
    chk("t6_err", m_err, 0);
    bus(1, 1, 0, 32'h5000_0000);
    s_ack = '0;
    #1;
    chk("t6_new_stall", m_stall, 0);
    chk("t6_new_sstb", s_stb, 16'h0020);
    bus(1, 0, 0, 32'h5000_0000);
    s_ack[5] = 1'b1;
    #1;
    chk("t6_new_ack", m_ack, 1);
    chk("t6_new_dat", m_dat_s, 32'hC0DE_0005);
    bus(0, 0, 0, 32'h0);
    s_ack = '0;
    #1;
    chk("t6_final_outcnt", dut.outcnt_q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
